// File: rtl/std_divmod_pipe.sv
// std_divmod_pipe: iterative restoring divider producing quotient and remainder together,
// under Calyx go/done handshake. SIGNED selects unsigned or two's-complement (truncating)
// semantics. Divide-by-zero, signed overflow (MIN / -1) and zero dividend are resolved in
// the start cycle; all other operands take WIDTH iteration cycles.
//
// Ports:
//   clk           clock, rising edge
//   reset_n       asynchronous active-low reset
//   go            start request, held high until done is seen; dropping it in RUN aborts
//   left, right   dividend and divisor, sampled only in the start cycle
//   out_quotient  registered quotient
//   out_remainder registered remainder (carries the dividend's sign in signed mode)
//   div_by_zero   registered flag, updated at every completion
//   done          one-cycle completion pulse
module std_divmod_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned SIGNED = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             div_by_zero,
   output logic             done
);

   localparam int unsigned W = WIDTH;

   typedef enum logic [1:0] {StIdle, StRun, StDone, StHold} state_e;

   state_e           state_q, state_d;
   logic [W-1:0]     dividend_q, dividend_d;
   logic [2*W-2:0]   divisor_q, divisor_d;
   logic [W-1:0]     mask_q, mask_d;
   logic [W-1:0]     quot_q, quot_d;
   logic             sign_q_q, sign_q_d;
   logic             sign_r_q, sign_r_d;
   logic [W-1:0]     oq_q, oq_d;
   logic [W-1:0]     or_q, or_d;
   logic             dbz_q, dbz_d;

   logic             left_neg, right_neg;
   logic [W-1:0]     left_mag, right_mag;
   logic             sub_ok;
   logic [W-1:0]     step_rem, step_quot;

   always_comb begin
      // Magnitudes in WIDTH-bit unsigned form; MIN maps onto itself, which is its magnitude.
      left_neg  = (SIGNED != 0) && left[W-1];
      right_neg = (SIGNED != 0) && right[W-1];
      left_mag  = left_neg  ? (-left)  : left;
      right_mag = right_neg ? (-right) : right;

      // One restoring step; when sub_ok the divisor fits in the low W bits.
      sub_ok    = (divisor_q <= {{(W-1){1'b0}}, dividend_q});
      step_rem  = sub_ok ? (dividend_q - divisor_q[W-1:0]) : dividend_q;
      step_quot = sub_ok ? (quot_q | mask_q) : quot_q;

      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      mask_d     = mask_q;
      quot_d     = quot_q;
      sign_q_d   = sign_q_q;
      sign_r_d   = sign_r_q;
      oq_d       = oq_q;
      or_d       = or_q;
      dbz_d      = dbz_q;

      unique case (state_q)
         StIdle: begin
            if (go) begin
               sign_q_d   = left_neg ^ right_neg;
               sign_r_d   = left_neg;
               dividend_d = left_mag;
               divisor_d  = {right_mag, {(W-1){1'b0}}};
               mask_d     = {1'b1, {(W-1){1'b0}}};
               quot_d     = '0;
               if (right == '0) begin
                  oq_d    = '1;
                  or_d    = left;
                  dbz_d   = 1'b1;
                  state_d = StDone;
               end else if (left == '0) begin
                  oq_d    = '0;
                  or_d    = '0;
                  dbz_d   = 1'b0;
                  state_d = StDone;
               end else if ((SIGNED != 0) && (left == {1'b1, {(W-1){1'b0}}})
                            && (right == '1)) begin
                  // MIN / -1 overflows; wrap to MIN like WIDTH-bit two's-complement.
                  oq_d    = left;
                  or_d    = '0;
                  dbz_d   = 1'b0;
                  state_d = StDone;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (!go) begin
               state_d = StIdle;
            end else begin
               dividend_d = step_rem;
               quot_d     = step_quot;
               divisor_d  = divisor_q >> 1;
               mask_d     = mask_q >> 1;
               if (mask_q[0]) begin
                  oq_d    = sign_q_q ? (-step_quot) : step_quot;
                  or_d    = sign_r_q ? (-step_rem) : step_rem;
                  dbz_d   = 1'b0;
                  state_d = StDone;
               end
            end
         end
         StDone: state_d = StHold;
         StHold: begin
            if (!go) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         dividend_q <= '0;
         divisor_q  <= '0;
         mask_q     <= '0;
         quot_q     <= '0;
         sign_q_q   <= 1'b0;
         sign_r_q   <= 1'b0;
         oq_q       <= '0;
         or_q       <= '0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         mask_q     <= mask_d;
         quot_q     <= quot_d;
         sign_q_q   <= sign_q_d;
         sign_r_q   <= sign_r_d;
         oq_q       <= oq_d;
         or_q       <= or_d;
         dbz_q      <= dbz_d;
      end
   end

   assign out_quotient  = oq_q;
   assign out_remainder = or_q;
   assign div_by_zero   = dbz_q;
   assign done          = (state_q == StDone);

endmodule

// File: tb/tb_std_divmod_pipe.sv
// Directed bench for std_divmod_pipe: one unsigned and one signed 8-bit instance share
// clock and reset. Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_std_divmod_pipe;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       go_u = 1'b0, go_s = 1'b0;
   logic [7:0] l_u = '0, r_u = '0, l_s = '0, r_s = '0;
   logic [7:0] q_u, rm_u, q_s, rm_s;
   logic       dz_u, dn_u, dz_s, dn_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   std_divmod_pipe #(.WIDTH(8), .SIGNED(0)) u_dut_u (
      .clk(clk), .reset_n(reset_n), .go(go_u), .left(l_u), .right(r_u),
      .out_quotient(q_u), .out_remainder(rm_u), .div_by_zero(dz_u), .done(dn_u)
   );

   std_divmod_pipe #(.WIDTH(8), .SIGNED(1)) u_dut_s (
      .clk(clk), .reset_n(reset_n), .go(go_s), .left(l_s), .right(r_s),
      .out_quotient(q_s), .out_remainder(rm_s), .div_by_zero(dz_s), .done(dn_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sgn, input bit g, input logic [7:0] l, input logic [7:0] r);
      if (sgn) begin go_s = g; l_s = l; r_s = r; end
      else     begin go_u = g; l_u = l; r_u = r; end
   endtask

   // Start in cycle 0, expect done first in cycle exp_cyc, then check results and holding.
   task automatic run_op(input string tag, input bit sgn, input logic [7:0] l,
                         input logic [7:0] r, input int exp_cyc, input logic [7:0] eq,
                         input logic [7:0] er, input bit edz);
      int first;
      logic [7:0] oq, orm;
      logic odz, odn;
      first = -1;
      @(negedge clk);
      drive(sgn, 1'b1, l, r);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         // Operands must be ignored after the start cycle.
         if (c == 1) drive(sgn, 1'b1, 8'($urandom), 8'($urandom));
         odn = sgn ? dn_s : dn_u;
         if (odn) begin
            first = c;
            break;
         end
      end
      check({tag, " done_cycle"}, first, exp_cyc);
      oq  = sgn ? q_s  : q_u;
      orm = sgn ? rm_s : rm_u;
      odz = sgn ? dz_s : dz_u;
      check({tag, " quotient"}, {24'd0, oq}, {24'd0, eq});
      check({tag, " remainder"}, {24'd0, orm}, {24'd0, er});
      check({tag, " div_by_zero"}, {31'd0, odz}, {31'd0, edz});
      @(negedge clk);
      odn = sgn ? dn_s : dn_u;
      check({tag, " done_pulse_len"}, {31'd0, odn}, 32'd0);
      drive(sgn, 1'b0, 8'd0, 8'd0);
      @(negedge clk);
      oq = sgn ? q_s : q_u;
      check({tag, " quotient_held"}, {24'd0, oq}, {24'd0, eq});
   endtask

   initial begin
      int saw_done;

      repeat (3) @(negedge clk);
      check("reset q_u", {24'd0, q_u}, 32'd0);
      check("reset r_u", {24'd0, rm_u}, 32'd0);
      check("reset dz_u", {31'd0, dz_u}, 32'd0);
      check("reset done_u", {31'd0, dn_u}, 32'd0);
      check("reset q_s", {24'd0, q_s}, 32'd0);
      check("reset done_s", {31'd0, dn_s}, 32'd0);
      reset_n = 1'b1;

      run_op("u100/7",   1'b0, 8'd100, 8'd7,  9, 8'd14,  8'd2,  1'b0);
      run_op("s-7/2",    1'b1, 8'hF9,  8'h02, 9, 8'hFD,  8'hFF, 1'b0);
      run_op("s7/-2",    1'b1, 8'h07,  8'hFE, 9, 8'hFD,  8'h01, 1'b0);
      run_op("u200/0",   1'b0, 8'd200, 8'd0,  1, 8'hFF,  8'hC8, 1'b1);
      run_op("u9/3",     1'b0, 8'd9,   8'd3,  9, 8'd3,   8'd0,  1'b0);
      run_op("sMIN/-1",  1'b1, 8'h80,  8'hFF, 1, 8'h80,  8'h00, 1'b0);
      run_op("sMIN/2",   1'b1, 8'h80,  8'h02, 9, 8'hC0,  8'h00, 1'b0);
      run_op("u0/5",     1'b0, 8'd0,   8'd5,  1, 8'd0,   8'd0,  1'b0);
      run_op("u100/7b",  1'b0, 8'd100, 8'd7,  9, 8'd14,  8'd2,  1'b0);

      // Abort: drop go in cycle 4 of RUN; no done, previous results held.
      saw_done = 0;
      @(negedge clk);
      drive(1'b0, 1'b1, 8'd100, 8'd7);
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 4) go_u = 1'b0;
         if (dn_u) saw_done++;
      end
      check("abort no_done", saw_done, 32'd0);
      check("abort q_held", {24'd0, q_u}, 32'd14);
      check("abort r_held", {24'd0, rm_u}, 32'd2);
      run_op("u9/3 restart", 1'b0, 8'd9, 8'd3, 9, 8'd3, 8'd0, 1'b0);

      // Asynchronous reset mid-RUN, between clock edges.
      @(negedge clk);
      drive(1'b0, 1'b1, 8'd100, 8'd7);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst q", {24'd0, q_u}, 32'd0);
      check("async_rst r", {24'd0, rm_u}, 32'd0);
      check("async_rst done", {31'd0, dn_u}, 32'd0);
      go_u = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      run_op("u255/16",  1'b0, 8'd255, 8'd16, 9, 8'd15, 8'd15, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/std_divmod_pipe.md
Name: std_divmod_pipe

Overview:
- Iterative restoring divider that returns quotient and remainder together from one operation, so callers no longer need separate div and mod units.
- SIGNED parameter selects unsigned or signed (truncating) semantics.
- Handles divide-by-zero and signed overflow explicitly, and supports an abort when go falls.
- Sits in the bitnum primitive library under Calyx go/done control.

Parameters:
WIDTH, 32, operand and result width in bits (>=2)
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands, quotient truncates toward zero

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
go  input  1  Calyx go; held high until done is seen
left  input  WIDTH  dividend, sampled only in the start cycle
right  input  WIDTH  divisor, sampled only in the start cycle
out_quotient  output  WIDTH  quotient, registered
out_remainder  output  WIDTH  remainder, registered
div_by_zero  output  1  set with done when right was 0
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset_n=0, asynchronous): FSM=IDLE; out_quotient, out_remainder, div_by_zero, done all 0; internal dividend/divisor/mask registers 0. Reset mid-operation abandons the operation with no done.
- FSM states:
  - IDLE: on go=1, latch operands (start cycle). Normal operands go to RUN; fast path goes to DONE.
  - RUN: WIDTH iteration cycles.
  - DONE: done=1 for exactly one cycle, then go to HOLD.
  - HOLD: stay while go=1; go=0 -> IDLE.
- Start cycle:
  - SIGNED=1: compute magnitudes |left| and |right| in WIDTH-bit unsigned form (MIN magnitude fits); record sign_q = left_msb ^ right_msb and sign_r = left_msb.
  - Load divisor as right_mag << (WIDTH-1) into a 2*WIDTH-1 bit register; mask = 1 << (WIDTH-1); quotient accumulator = 0.
- RUN, each cycle: if divisor <= dividend, subtract divisor from dividend and OR mask into quotient. Shift divisor and mask right by 1. Exit to DONE after the mask has covered bit 0 (WIDTH cycles).
- Latency: done is high in cycle WIDTH+1, counting the start cycle as 0.
- DONE entry:
  - Register out_quotient = sign_q ? -q : q.
  - Register out_remainder = sign_r ? -r : r. Remainder carries the dividend's sign; the invariant left = q*right + r holds in WIDTH-bit arithmetic.
  - Unsigned mode has no negation.
- Fast paths (start cycle -> DONE, done in cycle 1):
  - right==0: out_quotient = all ones, out_remainder = left unmodified, div_by_zero=1.
  - left==0 (right!=0): both results 0.
  - SIGNED=1, left=MIN and right=-1: out_quotient = MIN, out_remainder = 0, div_by_zero=0.
- div_by_zero is updated at every DONE entry and holds until the next DONE or reset.
- Outputs hold their values after done until the next DONE entry; they are not cleared when go falls.
- go=0 while in RUN: abort, return to IDLE next cycle, no done, outputs unchanged.
- go held high after done (HOLD): no restart; a new operation needs go low for at least one cycle.
- Operand changes after the start cycle have no effect on the result.

Test Plan:
- WIDTH=8 SIGNED=0, left=100 right=7, go held -> done in cycle 9 only; quotient=14, remainder=2, div_by_zero=0.
- WIDTH=8 SIGNED=1, left=0xF9(-7) right=2 -> quotient=0xFD(-3), remainder=0xFF(-1) at cycle 9. Repeat with left=7 right=0xFE -> quotient=0xFD, remainder=0x01.
- WIDTH=8 SIGNED=0, left=200 right=0 -> done in cycle 1; quotient=0xFF, remainder=0xC8, div_by_zero=1. Then 9/3 -> div_by_zero clears, quotient=3, remainder=0.
- WIDTH=8 SIGNED=1, left=0x80 right=0xFF -> done in cycle 1; quotient=0x80, remainder=0. Then left=0x80 right=0x02 -> quotient=0xC0(-64), remainder=0 at cycle 9.
- Abort: start 100/7, drop go at cycle 4, then restart with 9/3 -> no done during the abort; previous outputs held; new done 9 cycles after the restart start cycle with quotient=3, remainder=0.
- Assert reset_n=0 asynchronously mid-RUN -> outputs and done go to 0 immediately with no clock edge. After release with go=1, 255/16 -> quotient=15, remainder=15.
